compressed_line_packer: RTL and testbench

- Downstream packing stage of the Stage1+2 compressor.
- Takes one variable-length compressed code per handshake and concatenates the codes into a single CACHE_LINE-bit output line per compressed block.
- Pads the final line with zeros and presents it on a valid/ready output port.
- If a block's compressed size exceeds CACHE_LINE bits, the block is abandoned and a stop pulse tells control logic to send the line uncompressed.

---
 rtl/compressed_line_packer.sv | 128 ++++++++++++
 tb/tb_compressed_line_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_line_packer.sv
// Concatenates variable-length compressed codes into one CACHE_LINE-bit line per block.
// Blocks larger than CACHE_LINE bits are discarded and a one-cycle stop pulse is raised.
module compressed_line_packer #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 64,
  parameter int LEN_W      = 7,
  parameter int FILL_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WORD_SIZE-1:0]  i_code,
  input  logic [LEN_W-1:0]      i_length,
  input  logic                  i_last,
  output logic                  o_line_valid,
  input  logic                  i_line_ready,
  output logic [CACHE_LINE-1:0] o_line,
  output logic [FILL_W-1:0]     o_line_bits,
  output logic                  o_stop,
  output logic [FILL_W-1:0]     o_fill_level
);

  typedef enum logic [1:0] {ACCUM, DISCARD, EMIT} state_t;

  state_t                state_q, state_d;
  logic [CACHE_LINE-1:0] buffer_q, buffer_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [FILL_W-1:0]     line_bits_q, line_bits_d;
  logic                  line_valid_q, line_valid_d;
  logic                  stop_q, stop_d;

  logic [LEN_W-1:0]      len;
  logic [WORD_SIZE-1:0]  code_mask;
  logic [WORD_SIZE-1:0]  masked_code;
  logic [FILL_W:0]       fill_sum;
  logic [CACHE_LINE-1:0] placed_code;
  logic [CACHE_LINE-1:0] packed_buffer;
  logic                  accept;
  logic                  fits;

  assign o_ready       = (state_q != EMIT);
  assign accept        = i_valid & o_ready;
  assign len           = (i_length > LEN_W'(WORD_SIZE)) ? LEN_W'(WORD_SIZE) : i_length;
  // Shifting all-ones by the full word width yields zero, so len == WORD_SIZE keeps every bit.
  assign code_mask     = ~({WORD_SIZE{1'b1}} << len);
  assign masked_code   = i_code & code_mask;
  assign fill_sum      = {1'b0, fill_q} + (FILL_W+1)'(len);
  assign fits          = (fill_sum <= (FILL_W+1)'(CACHE_LINE));
  assign placed_code   = CACHE_LINE'(masked_code) << fill_q;
  assign packed_buffer = buffer_q | placed_code;

  always_comb begin
    state_d      = state_q;
    buffer_d     = buffer_q;
    fill_d       = fill_q;
    line_d       = line_q;
    line_bits_d  = line_bits_q;
    line_valid_d = line_valid_q;
    stop_d       = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (fits) begin
            buffer_d = packed_buffer;
            fill_d   = fill_sum[FILL_W-1:0];
            if (i_last) begin
              line_d       = packed_buffer;
              line_bits_d  = fill_sum[FILL_W-1:0];
              line_valid_d = 1'b1;
              state_d      = EMIT;
            end
          end else begin
            buffer_d = '0;
            fill_d   = '0;
            if (i_last) stop_d = 1'b1;
            else        state_d = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && i_last) begin
          stop_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      EMIT: begin
        if (i_line_ready) begin
          line_valid_d = 1'b0;
          buffer_d     = '0;
          fill_d       = '0;
          line_d       = '0;
          line_bits_d  = '0;
          state_d      = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ACCUM;
      buffer_q     <= '0;
      fill_q       <= '0;
      line_q       <= '0;
      line_bits_q  <= '0;
      line_valid_q <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      fill_q       <= fill_d;
      line_q       <= line_d;
      line_bits_q  <= line_bits_d;
      line_valid_q <= line_valid_d;
      stop_q       <= stop_d;
    end
  end

  assign o_line_valid = line_valid_q;
  assign o_line       = line_q;
  assign o_line_bits  = line_bits_q;
  assign o_stop       = stop_q;
  assign o_fill_level = fill_q;

endmodule

// File: tb/tb_compressed_line_packer.sv
// Self-checking bench for compressed_line_packer: directed cases plus random blocks
// compared against a bit-level reference model of the packing rules.
module tb_compressed_line_packer;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [63:0]   i_code = '0;
  logic [6:0]    i_length = '0;
  logic          i_last = 1'b0;
  logic          o_line_valid;
  logic          i_line_ready = 1'b0;
  logic [127:0]  o_line;
  logic [7:0]    o_line_bits;
  logic          o_stop;
  logic [7:0]    o_fill_level;

  int n_checks = 0;
  int n_fails  = 0;

  logic [127:0] m_line;
  int           m_fill;
  bit           m_discard;
  bit           m_emit;

  compressed_line_packer dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_code       (i_code),
    .i_length     (i_length),
    .i_last       (i_last),
    .o_line_valid (o_line_valid),
    .i_line_ready (i_line_ready),
    .o_line       (o_line),
    .o_line_bits  (o_line_bits),
    .o_stop       (o_stop),
    .o_fill_level (o_fill_level)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelClear();
    m_line    = '0;
    m_fill    = 0;
    m_discard = 1'b0;
    m_emit    = 1'b0;
  endtask

  // One beat: drive away from the edge, let the rising edge accept it, then compare.
  task automatic applyStimulus(input logic [63:0] code, input int len, input bit last);
    int lenc;
    bit exp_stop;
    @(negedge i_clk);
    checkOutput("ready_before_beat", 128'(o_ready), 128'(1));
    i_valid  = 1'b1;
    i_code   = code;
    i_length = 7'(len);
    i_last   = last;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    lenc = (len > 64) ? 64 : len;
    exp_stop = 1'b0;
    if (m_discard) begin
      if (last) begin
        m_discard = 1'b0;
        exp_stop  = 1'b1;
      end
    end else if (m_fill + lenc <= 128) begin
      for (int b = 0; b < lenc; b++) m_line[m_fill + b] = code[b];
      m_fill = m_fill + lenc;
      if (last) m_emit = 1'b1;
    end else begin
      m_line = '0;
      m_fill = 0;
      if (last) exp_stop = 1'b1;
      else      m_discard = 1'b1;
    end
    checkOutput("stop", 128'(o_stop), 128'(exp_stop));
    checkOutput("line_valid", 128'(o_line_valid), 128'(m_emit));
    checkOutput("fill_level", 128'(o_fill_level), 128'(m_fill));
    if (m_emit) begin
      checkOutput("line", o_line, m_line);
      checkOutput("line_bits", 128'(o_line_bits), 128'(m_fill));
      checkOutput("ready_in_emit", 128'(o_ready), 128'(0));
    end
  endtask

  // Hold the line for some cycles while offering beats that must be ignored, then release it.
  task automatic drainLine(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      i_valid      = 1'b1;
      i_code       = {$urandom, $urandom};
      i_length     = 7'($urandom_range(0, 64));
      i_last       = 1'($urandom_range(0, 1));
      i_line_ready = 1'b0;
      @(posedge i_clk);
      #1;
      checkOutput("hold_line", o_line, m_line);
      checkOutput("hold_valid", 128'(o_line_valid), 128'(1));
      checkOutput("hold_ready", 128'(o_ready), 128'(0));
      checkOutput("hold_fill", 128'(o_fill_level), 128'(m_fill));
      checkOutput("hold_stop", 128'(o_stop), 128'(0));
    end
    @(negedge i_clk);
    i_valid      = 1'b0;
    i_last       = 1'b0;
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
    modelClear();
    checkOutput("release_valid", 128'(o_line_valid), 128'(0));
    checkOutput("release_ready", 128'(o_ready), 128'(1));
    checkOutput("release_fill", 128'(o_fill_level), 128'(0));
    checkOutput("release_line", o_line, 128'(0));
    checkOutput("release_bits", 128'(o_line_bits), 128'(0));
  endtask

  task automatic idleCycle();
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    checkOutput("idle_stop", 128'(o_stop), 128'(0));
    checkOutput("idle_valid", 128'(o_line_valid), 128'(m_emit));
    checkOutput("idle_fill", 128'(o_fill_level), 128'(m_fill));
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_last  = 1'b1;
    i_code  = {$urandom, $urandom};
    i_length = 7'd5;
    i_line_ready = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_line_ready = 1'b0;
    modelClear();
    checkOutput("rst_valid", 128'(o_line_valid), 128'(0));
    checkOutput("rst_line", o_line, 128'(0));
    checkOutput("rst_bits", 128'(o_line_bits), 128'(0));
    checkOutput("rst_stop", 128'(o_stop), 128'(0));
    checkOutput("rst_fill", 128'(o_fill_level), 128'(0));
    checkOutput("rst_ready", 128'(o_ready), 128'(1));
  endtask

  initial begin
    logic [63:0] all_ones;
    int nbeats;
    all_ones = '1;
    modelClear();
    doReset();

    // Exact-fit block of 34+30+64 bits, held for a few cycles.
    applyStimulus({$urandom, $urandom}, 34, 1'b0);
    applyStimulus({$urandom, $urandom}, 30, 1'b0);
    applyStimulus({$urandom, $urandom}, 64, 1'b1);
    checkOutput("exact_bits", 128'(o_line_bits), 128'(128));
    drainLine(3);

    // Two short codes with garbage above their lengths.
    applyStimulus(64'hFFFF_FFFF_FFFA_BCDE, 20, 1'b0);
    applyStimulus(64'h1234_5678_9ABC_DFFF, 9, 1'b1);
    checkOutput("short_pack", o_line, {99'd0, 9'h1FF, 20'hABCDE});
    drainLine(0);

    // Overflow on the third beat; fourth beat dropped, single stop pulse.
    applyStimulus({$urandom, $urandom}, 64, 1'b0);
    applyStimulus({$urandom, $urandom}, 64, 1'b0);
    applyStimulus({$urandom, $urandom}, 1, 1'b0);
    applyStimulus({$urandom, $urandom}, 10, 1'b1);
    idleCycle();

    // Long hold of a line.
    applyStimulus({$urandom, $urandom}, 40, 1'b1);
    drainLine(5);

    // Masking to 4 bits, then a clamped length of 100.
    applyStimulus(all_ones, 4, 1'b1);
    checkOutput("mask4", o_line, 128'hF);
    drainLine(1);
    applyStimulus(all_ones, 100, 1'b0);
    applyStimulus({$urandom, $urandom}, 0, 1'b1);
    checkOutput("clamp_bits", 128'(o_line_bits), 128'(64));
    drainLine(0);

    // Empty block.
    applyStimulus({$urandom, $urandom}, 0, 1'b1);
    checkOutput("empty_line", o_line, 128'(0));
    drainLine(0);

    // Reset during EMIT, then during DISCARD, then a clean block.
    applyStimulus({$urandom, $urandom}, 50, 1'b1);
    doReset();
    applyStimulus({$urandom, $urandom}, 64, 1'b0);
    applyStimulus({$urandom, $urandom}, 64, 1'b0);
    applyStimulus({$urandom, $urandom}, 3, 1'b0);
    doReset();
    applyStimulus({$urandom, $urandom}, 17, 1'b0);
    applyStimulus({$urandom, $urandom}, 8, 1'b1);
    drainLine(1);
    idleCycle();

    // Random blocks.
    for (int blk = 0; blk < 60; blk++) begin
      nbeats = $urandom_range(1, 5);
      for (int k = 0; k < nbeats; k++)
        applyStimulus({$urandom, $urandom}, $urandom_range(0, 80), k == nbeats - 1);
      if (m_emit) drainLine($urandom_range(0, 3));
      else        idleCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
